// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg : shared types and constants for the memory bus arbiter
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_t;

  // Round-robin pointer values: the owner favoured on the next tie
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int ERR_DATA = 0;

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// bus_watchdog : per-transaction cycle counter, flags expiry on the TIMEOUT-th cycle
// Revision: 1.0 - initial release
// ============================================================================
module bus_watchdog
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClr,
  input  logic iEn,
  output logic oExpire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_max  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge iCLK) begin
    if (!iRST || iClr) begin
      r_count <= '0;
    end else if (iEn && (r_count != c_max)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // The count holds cycles already elapsed, so the edge ending the TIMEOUT-th cycle expires
  assign oExpire = iEn && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : round-robin sharing of one memory port between fetch and data buses
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int DATA_FIRST = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iIReq,
  input  logic [ADDR_W-1:0] iIAddr,
  output logic              oIValid,
  output logic [DATA_W-1:0] oIData,
  input  logic              iDReq,
  input  logic              iDWe,
  input  logic [3:0]        iDBe,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWData,
  output logic              oDValid,
  output logic [DATA_W-1:0] oDData,
  output logic              oMReq,
  output logic              oMWe,
  output logic [3:0]        oMBe,
  output logic [ADDR_W-1:0] oMAddr,
  output logic [DATA_W-1:0] oMWData,
  input  logic              iMAck,
  input  logic [DATA_W-1:0] iMRData,
  output logic              oErr
);

  localparam logic [DATA_W-1:0] c_errData = DATA_W'(ERR_DATA);
  localparam logic              c_ptrInit = (DATA_FIRST != 0) ? OWNER_D : OWNER_I;

  arbState_t         r_state, w_stateNext;
  logic              r_ptr, w_ptrNext;
  logic              w_mReqNext, w_mWeNext, w_iValidNext, w_dValidNext, w_errNext;
  logic [3:0]        w_mBeNext;
  logic [ADDR_W-1:0] w_mAddrNext;
  logic [DATA_W-1:0] w_mWDataNext, w_iDataNext, w_dDataNext;
  logic              w_iElig, w_dElig, w_grantI, w_grantD, w_busy, w_expire;

  // A requester still holding its request during its own valid pulse is masked
  assign w_iElig  = iIReq && !oIValid;
  assign w_dElig  = iDReq && !oDValid;
  assign w_grantD = w_dElig && (!w_iElig || (r_ptr == OWNER_D));
  assign w_grantI = w_iElig && !w_grantD;
  assign w_busy   = (r_state != IDLE);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) uWatchdog (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iClr    (!w_busy),
    .iEn     (w_busy),
    .oExpire (w_expire)
  );

  always_comb begin
    w_stateNext  = r_state;
    w_ptrNext    = r_ptr;
    w_mReqNext   = oMReq;
    w_mWeNext    = oMWe;
    w_mBeNext    = oMBe;
    w_mAddrNext  = oMAddr;
    w_mWDataNext = oMWData;
    w_iValidNext = 1'b0;
    w_dValidNext = 1'b0;
    w_errNext    = 1'b0;
    w_iDataNext  = oIData;
    w_dDataNext  = oDData;
    case (r_state)
      IDLE: begin
        if (w_grantD) begin
          w_stateNext  = BUSY_D;
          w_ptrNext    = OWNER_I;
          w_mReqNext   = 1'b1;
          w_mWeNext    = iDWe;
          w_mBeNext    = iDBe;
          w_mAddrNext  = iDAddr;
          w_mWDataNext = iDWData;
        end else if (w_grantI) begin
          w_stateNext  = BUSY_I;
          w_ptrNext    = OWNER_D;
          w_mReqNext   = 1'b1;
          w_mWeNext    = 1'b0;
          w_mBeNext    = 4'b1111;
          w_mAddrNext  = iIAddr;
          w_mWDataNext = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // Ack is checked first so an ack on the expiry edge still returns data
        if (iMAck || w_expire) begin
          w_stateNext = IDLE;
          w_mReqNext  = 1'b0;
          w_errNext   = !iMAck;
          if (r_state == BUSY_I) begin
            w_iValidNext = 1'b1;
            w_iDataNext  = iMAck ? iMRData : c_errData;
          end else begin
            w_dValidNext = 1'b1;
            w_dDataNext  = (iMAck && !oMWe) ? iMRData : c_errData;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state <= IDLE;
      r_ptr   <= c_ptrInit;
      oMReq   <= 1'b0;
      oMWe    <= 1'b0;
      oMBe    <= '0;
      oMAddr  <= '0;
      oMWData <= '0;
      oIValid <= 1'b0;
      oDValid <= 1'b0;
      oErr    <= 1'b0;
      oIData  <= '0;
      oDData  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      oMReq   <= w_mReqNext;
      oMWe    <= w_mWeNext;
      oMBe    <= w_mBeNext;
      oMAddr  <= w_mAddrNext;
      oMWData <= w_mWDataNext;
      oIValid <= w_iValidNext;
      oDValid <= w_dValidNext;
      oErr    <= w_errNext;
      oIData  <= w_iDataNext;
      oDData  <= w_dDataNext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : directed self-checking bench for mem_bus_arbiter (TIMEOUT=4)
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iIReq, iDReq, iDWe, iMAck;
  logic [3:0]  iDBe;
  logic [31:0] iIAddr, iDAddr, iDWData, iMRData;
  logic        oIValid, oDValid, oMReq, oMWe, oErr;
  logic [31:0] oIData, oDData, oMAddr, oMWData;
  logic [3:0]  oMBe;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] c_addrI = 32'h0040_0000;
  localparam logic [31:0] c_addrD = 32'h1000_0020;

  always #5 iCLK = ~iCLK;

  mem_bus_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT    (4),
    .DATA_FIRST (1)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iIReq   (iIReq),
    .iIAddr  (iIAddr),
    .oIValid (oIValid),
    .oIData  (oIData),
    .iDReq   (iDReq),
    .iDWe    (iDWe),
    .iDBe    (iDBe),
    .iDAddr  (iDAddr),
    .iDWData (iDWData),
    .oDValid (oDValid),
    .oDData  (oDData),
    .oMReq   (oMReq),
    .oMWe    (oMWe),
    .oMBe    (oMBe),
    .oMAddr  (oMAddr),
    .oMWData (oMWData),
    .iMAck   (iMAck),
    .iMRData (iMRData),
    .oErr    (oErr)
  );

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    iRST = 1'b0; iIReq = 1'b0; iDReq = 1'b0; iDWe = 1'b0; iMAck = 1'b0;
    iDBe = 4'h0; iIAddr = '0; iDAddr = '0; iDWData = '0; iMRData = '0;
    step(); step();
    chk("rst_mreq", oMReq, 0);
    chk("rst_ivalid", oIValid, 0);
    chk("rst_dvalid", oDValid, 0);
    chk("rst_err", oErr, 0);
    iRST = 1'b1;
    step();

    // Single fetch, ack in oMReq's second cycle
    iIReq = 1'b1; iIAddr = c_addrI;
    step();
    chk("f_mreq1", oMReq, 1);
    chk("f_addr", oMAddr, c_addrI);
    chk("f_be", oMBe, 4'hF);
    chk("f_we", oMWe, 0);
    step();
    chk("f_mreq2", oMReq, 1);
    iMAck = 1'b1; iMRData = 32'h0000_0013;
    step();
    chk("f_ivalid", oIValid, 1);
    chk("f_idata", oIData, 32'h13);
    chk("f_mreq_low", oMReq, 0);
    iIReq = 1'b0; iMAck = 1'b0;
    step();
    chk("f_pulse", oIValid, 0);
    chk("f_idle", oMReq, 0);

    // Collision after reset: D, I, D, I with both held
    iRST = 1'b0; step(); iRST = 1'b1; step();
    iIReq = 1'b1; iIAddr = c_addrI;
    iDReq = 1'b1; iDWe = 1'b0; iDBe = 4'hF; iDAddr = c_addrD;
    step();
    chk("c1_addr", oMAddr, c_addrD);
    iMAck = 1'b1; iMRData = 32'h11;
    step();
    chk("c1_dvalid", oDValid, 1);
    chk("c1_ddata", oDData, 32'h11);
    chk("c1_mreq", oMReq, 0);
    iMAck = 1'b0;
    step();
    chk("c2_addr", oMAddr, c_addrI);
    chk("c2_mreq", oMReq, 1);
    chk("c2_dpulse", oDValid, 0);
    iMAck = 1'b1; iMRData = 32'h22;
    step();
    chk("c2_ivalid", oIValid, 1);
    chk("c2_idata", oIData, 32'h22);
    iMAck = 1'b0;
    step();
    chk("c3_addr", oMAddr, c_addrD);
    iMAck = 1'b1; iMRData = 32'h33;
    step();
    chk("c3_dvalid", oDValid, 1);
    chk("c3_ddata", oDData, 32'h33);
    iMAck = 1'b0;
    step();
    chk("c4_addr", oMAddr, c_addrI);
    chk("c4_be", oMBe, 4'hF);
    iMAck = 1'b1; iMRData = 32'h44;
    step();
    chk("c4_ivalid", oIValid, 1);
    chk("c4_idata", oIData, 32'h44);
    iIReq = 1'b0; iDReq = 1'b0; iMAck = 1'b0;
    step();
    chk("c_idle", oMReq, 0);

    // Store: operands frozen even when the requester changes them mid-flight
    iDReq = 1'b1; iDWe = 1'b1; iDBe = 4'b0011; iDAddr = 32'h1001_0004; iDWData = 32'hCAFE_BABE;
    step();
    chk("s_mreq", oMReq, 1);
    chk("s_we", oMWe, 1);
    chk("s_be", oMBe, 4'b0011);
    chk("s_addr", oMAddr, 32'h1001_0004);
    chk("s_wdata", oMWData, 32'hCAFE_BABE);
    iDWData = 32'h1234_5678; iDBe = 4'hF;
    step();
    chk("s_wdata_hold", oMWData, 32'hCAFE_BABE);
    chk("s_be_hold", oMBe, 4'b0011);
    iMAck = 1'b1; iMRData = 32'hDEAD_BEEF;
    step();
    chk("s_dvalid", oDValid, 1);
    chk("s_ddata", oDData, 0);
    chk("s_err", oErr, 0);
    iDReq = 1'b0; iDWe = 1'b0; iDBe = 4'hF; iMAck = 1'b0;
    step();

    // Timeout: oMReq high exactly 4 cycles, then valid + err with data 0
    iDReq = 1'b1; iDAddr = 32'h0000_0100;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t_mreq_hi", oMReq, 1);
      chk("t_no_valid", oDValid, 0);
    end
    step();
    chk("t_mreq_lo", oMReq, 0);
    chk("t_dvalid", oDValid, 1);
    chk("t_err", oErr, 1);
    chk("t_ddata", oDData, 0);
    iDReq = 1'b0;
    step();
    chk("t_err_pulse", oErr, 0);
    chk("t_idle", oMReq, 0);

    // Ack on the expiry cycle wins over the timeout
    iIReq = 1'b1; iIAddr = 32'h0000_0200;
    step(); step(); step(); step();
    chk("a_mreq4", oMReq, 1);
    iMAck = 1'b1; iMRData = 32'h55;
    step();
    chk("a_ivalid", oIValid, 1);
    chk("a_err", oErr, 0);
    chk("a_idata", oIData, 32'h55);
    iIReq = 1'b0; iMAck = 1'b0;
    step();

    // Reset during BUSY_I drops the fetch silently
    iIReq = 1'b1; iIAddr = 32'h0000_0300;
    step();
    chk("r_busy", oMReq, 1);
    iRST = 1'b0;
    step();
    chk("r_mreq", oMReq, 0);
    chk("r_maddr", oMAddr, 0);
    chk("r_mbe", oMBe, 0);
    chk("r_ivalid", oIValid, 0);
    iRST = 1'b1; iIReq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r_no_ivalid", oIValid, 0);
      chk("r_no_err", oErr, 0);
    end

    // Data-only grant moves the pointer to I; reset must restore data priority
    iDReq = 1'b1; iDWe = 1'b0; iDAddr = c_addrD;
    step();
    chk("p_d_addr", oMAddr, c_addrD);
    iMAck = 1'b1; iMRData = 32'h66;
    step();
    chk("p_dvalid", oDValid, 1);
    iDReq = 1'b0; iMAck = 1'b0;
    iRST = 1'b0; step(); iRST = 1'b1;
    iIReq = 1'b1; iIAddr = c_addrI; iDReq = 1'b1;
    step();
    step();
    chk("p_first_d", oMAddr, c_addrD);
    iMAck = 1'b1; iMRData = 32'h77;
    step();
    chk("p_ddata", oDData, 32'h77);
    iIReq = 1'b0; iDReq = 1'b0; iMAck = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
